serial_frame_router: RTL
========================

// Module: serial_frame_router
// PURPOSE
//  Parametrised successor of the single-channel serial device.
//  Receives a serial frame on a 1-bit line: start bit, channel address, payload length, payload.
//  Forwards the payload bits to one of 2**CH_BITS output channels, each with its own valid line.
//  Sits between the serial input pin and the per-channel consumers.
// PARAMETERS
//  CH_BITS     2  address width; number of channels NCH = 2**CH_BITS
//  LEN_BITS    4  length-field width; payload is 0 .. 2**LEN_BITS-1 bits
//  START_LEVEL 0  line level that marks a start bit; the opposite level is idle
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-low reset
//  in         in   1         serial line, sampled on every rising clk edge
//  out        out  1         registered payload bit
//  out_valid  out  NCH       one-hot; bit k high => out is a payload bit for channel k
//  busy       out  1         high while a frame is in progress (any state except IDLE)
//  frame_done out  1         one-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; out=0, out_valid=0, busy=0, frame_done=0; counters and shifters=0.
//  FSM states: IDLE, ADDR, LEN, DATA.
//   IDLE: sample in==START_LEVEL -> ADDR. Any other level stays in IDLE.
//   ADDR: shift in CH_BITS bits, MSB first; after the last bit -> LEN.
//   LEN:  shift in LEN_BITS bits, MSB first; after the last bit:
//         len!=0 -> DATA, with cnt=len;
//         len==0 -> IDLE, pulse frame_done next cycle, no out_valid.
//   DATA: every edge: out<=in, out_valid<=onehot(addr), cnt<=cnt-1;
//         cnt==1 -> IDLE, and frame_done<=1 in the same edge.
//  Latency: each payload bit appears on out/out_valid 1 cycle after it is sampled.
//  Outside DATA: out_valid=0; out holds its last value.
//  frame_done is coincident with out_valid of the final bit.
//  busy is registered: high from the edge that samples the start bit.
//   It drops on the edge that leaves DATA (or leaves LEN when len==0).
//  Back-to-back: the cycle after the last payload bit is IDLE.
//   A start bit there is accepted, so there are zero idle bits between frames.
//  Payload bits equal to START_LEVEL are never treated as start bits.
//  Reset mid-frame: the frame is dropped and all outputs clear immediately.
//   After release, the first START_LEVEL sample begins a new frame.
//  Widths: cnt is LEN_BITS wide and never wraps; addr stays fixed for the whole frame.
// STRUCTURE
//  Package serial_frame_pkg holds:
//   - state encoding localparams (IDLE=0, ADDR=1, LEN=2, DATA=3);
//   - the default CH_BITS and LEN_BITS;
//   - a function onehot(addr) returning NCH bits.
//  One sub-module, sipo_shift #(W): serial-in/parallel-out shifter with a bit counter and a "full" flag.
//  It is instanced twice, for the address field and the length field.
//  The top level holds the FSM, the payload down-counter and the output registers.
// TESTING (CH_BITS=2, LEN_BITS=4, START_LEVEL=0, 100ns clk)
//  1. Hold rst low, drive in=1 for 5 cycles -> all outputs stay 0; busy=0.
//  2. Send 0, addr 10, len 0011, data 1,0,1 -> out_valid=4'b0100 for 3 cycles.
//     out=1,0,1 over those cycles; frame_done high on the 3rd; busy low after.
//  3. Send 0, addr 11, len 0000 -> no out_valid; frame_done pulses once; back in IDLE.
//  4. Send frame A (addr 00, len 0010, data 0,0), then frame B (addr 01, len 0001, data 1) with no gap.
//     -> out_valid=0001 for 2 cycles, then 0 for 1+2+4=7 cycles, then 0010 for 1 cycle.
//  5. Start addr 01, len 1111; assert rst after the 4th data bit.
//     -> outputs clear at once; the next frame (addr 00, len 0001, data 1) routes to 0001.
//  6. Send len 1111 with data all 0s -> 15 valid bits and no false start.
//     Idle 1s after the frame -> the FSM stays in IDLE.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame router: FSM state encoding,
// default field widths and the channel one-hot decoder.
package serial_frame_pkg;

  localparam int CH_BITS_DEF  = 2;
  localparam int LEN_BITS_DEF = 4;

  // Upper bound on the address width; onehot() is sized for it and callers truncate.
  localparam int MAX_CH_BITS = 8;
  localparam int MAX_NCH     = 2 ** MAX_CH_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    LEN  = 2'd2,
    DATA = 2'd3
  } state_e;

  function automatic logic [MAX_NCH-1:0] onehot(input logic [MAX_CH_BITS-1:0] addr);
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/serial_frame_router_sipo.sv
// Serial-in/parallel-out field shifter, MSB first, with a bit counter.
// last_o flags the shift that completes the field so the FSM can move on that same edge.
module sipo_shift
  import serial_frame_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         full_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          shift_ok;

  // Once full the field is frozen, so the captured value stays stable until cleared.
  assign shift_ok = shift_i && !full_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clear_i) begin
      data_d = '0;
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (shift_ok) begin
      data_d = (data_q << 1) | W'(bit_i);
      cnt_d  = cnt_q + CW'(1);
      full_d = (cnt_q == CW'(W - 1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign last_o = shift_ok && (cnt_q == CW'(W - 1));
  assign full_o = full_q;

endmodule

// File: rtl/serial_frame_router.sv
// Serial frame router: start bit, channel address, payload length, then payload
// bits forwarded one cycle later on out_o with a per-channel one-hot valid.
module serial_frame_router
  import serial_frame_pkg::*;
#(
  parameter int   CH_BITS     = CH_BITS_DEF,
  parameter int   LEN_BITS    = LEN_BITS_DEF,
  parameter logic START_LEVEL = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_i,
  output logic                  out_o,
  output logic [2**CH_BITS-1:0] out_valid_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int NCH = 2 ** CH_BITS;

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                out_q, out_d;
  logic [NCH-1:0]      valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                clear_fields;
  logic                addr_shift, addr_last, addr_full;
  logic                len_shift, len_last, len_full;
  logic [CH_BITS-1:0]  addr_data;
  logic [LEN_BITS-1:0] len_data, len_now;

  sipo_shift #(.W(CH_BITS)) u_addr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_fields),
    .shift_i (addr_shift),
    .bit_i   (in_i),
    .data_o  (addr_data),
    .last_o  (addr_last),
    .full_o  (addr_full)
  );

  sipo_shift #(.W(LEN_BITS)) u_len (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_fields),
    .shift_i (len_shift),
    .bit_i   (in_i),
    .data_o  (len_data),
    .last_o  (len_last),
    .full_o  (len_full)
  );

  // Length including the bit being sampled now, so DATA can be entered without a gap.
  assign len_now = (len_data << 1) | LEN_BITS'(in_i);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    valid_d      = '0;
    done_d       = 1'b0;
    addr_shift   = 1'b0;
    len_shift    = 1'b0;
    clear_fields = 1'b0;
    case (state_q)
      IDLE: begin
        clear_fields = 1'b1;
        if (in_i == START_LEVEL) state_d = ADDR;
      end
      ADDR: begin
        addr_shift = !addr_full;
        if (addr_last) state_d = LEN;
      end
      LEN: begin
        len_shift = !len_full;
        if (len_last) begin
          if (len_now != '0) begin
            state_d = DATA;
            cnt_d   = len_now;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DATA: begin
        out_d   = in_i;
        valid_d = NCH'(onehot(MAX_CH_BITS'(addr_data)));
        cnt_d   = cnt_q - LEN_BITS'(1);
        if (cnt_q == LEN_BITS'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_o        = out_q;
  assign out_valid_o  = valid_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule
